// File: rtl/gsim_pkg.sv
// Shared constants, state encoding and constant-multiply helper for the GSIM residual checker.
package gsim_pkg;

  localparam int unsigned GSIM_N = 16;

  // Band coefficients of the pentadiagonal-plus matrix.
  localparam int unsigned C0 = 20;
  localparam int unsigned C1 = 13;
  localparam int unsigned C2 = 6;
  localparam int unsigned C3 = 1;

  // Width of each coefficient in bits; C0 needs the most.
  localparam int unsigned C_BITS = 5;

  localparam int unsigned ACC_W  = 39;
  localparam int unsigned FRAC_W = 16;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-32){1'b0}}, 32'h7FFF_FFFF};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-32){1'b1}}, 32'h8000_0000};
  localparam logic [31:0]             ABS_MAX = 32'h7FFF_FFFF;

  typedef enum logic [1:0] {LOAD, CALC, FIN} state_t;

  // Multiply by a constant as a sum of shifted copies, one per set coefficient bit.
  function automatic logic signed [ACC_W-1:0] mul_const(input logic signed [ACC_W-1:0] v,
                                                        input int unsigned c);
    logic signed [ACC_W-1:0] s;
    s = '0;
    for (int unsigned k = 0; k < C_BITS; k++) begin
      if (c[k]) s = s + (v <<< k);
    end
    return s;
  endfunction

endpackage

// File: rtl/gsim_row_eval.sv
// Combinational residual for one row: band product of seven x words minus scaled b, saturated.
module gsim_row_eval import gsim_pkg::*; (
  input  logic [31:0] x_m3,
  input  logic [31:0] x_m2,
  input  logic [31:0] x_m1,
  input  logic [31:0] x_0,
  input  logic [31:0] x_p1,
  input  logic [31:0] x_p2,
  input  logic [31:0] x_p3,
  input  logic [3:0]  row,
  input  logic [15:0] b_i,
  output logic [31:0] r_sat
);

  function automatic logic signed [ACC_W-1:0] sx(input logic [31:0] w, input logic keep);
    return keep ? {{(ACC_W-32){w[31]}}, w} : '0;
  endfunction

  logic signed [ACC_W-1:0] s0, s1, s2, s3, acc, bsh, r;

  // Sum symmetric neighbours with edge masking, weight them and subtract b_i << 16.
  always_comb begin
    s0  = sx(x_0, 1'b1);
    s1  = sx(x_m1, row >= 4'd1) + sx(x_p1, row <= 4'd14);
    s2  = sx(x_m2, row >= 4'd2) + sx(x_p2, row <= 4'd13);
    s3  = sx(x_m3, row >= 4'd3) + sx(x_p3, row <= 4'd12);
    acc = mul_const(s0, C0) - mul_const(s1, C1) + mul_const(s2, C2) - mul_const(s3, C3);
    bsh = {{(ACC_W-16-FRAC_W){b_i[15]}}, b_i, {FRAC_W{1'b0}}};
    r   = acc - bsh;
    if (r > SAT_MAX)      r_sat = 32'h7FFF_FFFF;
    else if (r < SAT_MIN) r_sat = 32'h8000_0000;
    else                  r_sat = r[31:0];
  end

endmodule

// File: rtl/gsim_residual.sv
// GSIM convergence checker: captures b and x, streams saturated residuals, tracks max |r|.
module gsim_residual import gsim_pkg::*; #(
  parameter int unsigned N = GSIM_N
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_en,
  input  logic [15:0] b_in,
  input  logic        x_valid,
  input  logic [31:0] x_in,
  output logic        res_valid,
  output logic [31:0] res_out,
  output logic        done,
  output logic [31:0] max_abs,
  output logic        busy
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned RW = $clog2(N);

  state_t         state_q, state_d;
  logic [CW-1:0]  bcnt_q, bcnt_d, xcnt_q, xcnt_d;
  logic [RW-1:0]  row_q, row_d;
  logic [15:0]    bmem_q [N];
  logic [15:0]    bmem_d [N];
  logic [31:0]    xmem_q [N];
  logic [31:0]    xmem_d [N];
  logic           res_valid_q, res_valid_d, done_q, done_d, busy_q, busy_d;
  logic [31:0]    res_q, res_d, max_q, max_d;
  logic           b_acc, x_acc, full;
  logic [31:0]    r_sat, r_abs;

  // Neighbour indices wrap modulo N; the evaluator masks out-of-range ones by row.
  gsim_row_eval u_eval (
    .x_m3  (xmem_q[row_q - RW'(3)]),
    .x_m2  (xmem_q[row_q - RW'(2)]),
    .x_m1  (xmem_q[row_q - RW'(1)]),
    .x_0   (xmem_q[row_q]),
    .x_p1  (xmem_q[row_q + RW'(1)]),
    .x_p2  (xmem_q[row_q + RW'(2)]),
    .x_p3  (xmem_q[row_q + RW'(3)]),
    .row   (row_q),
    .b_i   (bmem_q[row_q]),
    .r_sat (r_sat)
  );

  // State register and control flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD;
      bcnt_q      <= '0;
      xcnt_q      <= '0;
      row_q       <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      done_q      <= 1'b0;
      max_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      xcnt_q      <= xcnt_d;
      row_q       <= row_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
      done_q      <= done_d;
      max_q       <= max_d;
      busy_q      <= busy_d;
    end
  end

  // Operand memories are not reset; counters decide what is valid.
  always_ff @(posedge clk) begin
    bmem_q <= bmem_d;
    xmem_q <= xmem_d;
  end

  // Next-state logic: LOAD until both streams are full, 16 CALC rows, one FIN cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (full) state_d = CALC;
      CALC:    if (row_q == RW'(N - 1)) state_d = FIN;
      FIN:     state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Datapath and outputs: stream capture, row sequencing, residual register, max tracker.
  always_comb begin
    full        = (bcnt_q == CW'(N)) && (xcnt_q == CW'(N));
    b_acc       = (state_q == LOAD) && in_en   && (bcnt_q != CW'(N));
    x_acc       = (state_q == LOAD) && x_valid && (xcnt_q != CW'(N));
    r_abs       = (r_sat == 32'h8000_0000) ? ABS_MAX : (r_sat[31] ? -r_sat : r_sat);
    bmem_d      = bmem_q;
    xmem_d      = xmem_q;
    bcnt_d      = bcnt_q;
    xcnt_d      = xcnt_q;
    row_d       = row_q;
    res_d       = res_q;
    max_d       = max_q;
    res_valid_d = (state_q == CALC);
    done_d      = (state_q == FIN);
    busy_d      = busy_q;
    if (b_acc) begin
      bmem_d[bcnt_q[RW-1:0]] = b_in;
      bcnt_d                 = bcnt_q + 1'b1;
    end
    if (x_acc) begin
      xmem_d[xcnt_q[RW-1:0]] = x_in;
      xcnt_d                 = xcnt_q + 1'b1;
    end
    unique case (state_q)
      LOAD: begin
        row_d = '0;
        if (full) max_d = '0;
      end
      CALC: begin
        row_d = row_q + 1'b1;
        res_d = r_sat;
        if (r_abs > max_q) max_d = r_abs;
      end
      FIN: begin
        bcnt_d = '0;
        xcnt_d = '0;
      end
      default: ;
    endcase
    // busy drops the cycle after done, unless a new job's first word lands then.
    if (done_q) busy_d = 1'b0;
    if (b_acc || x_acc) busy_d = 1'b1;
  end

  assign res_valid = res_valid_q;
  assign res_out   = res_q;
  assign done      = done_q;
  assign max_abs   = max_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_gsim_residual.sv
// Directed table-driven bench for gsim_residual.
module tb_gsim_residual;

  logic        clk = 1'b0;
  logic        reset, in_en, x_valid;
  logic [15:0] b_in;
  logic [31:0] x_in;
  logic        res_valid, done, busy;
  logic [31:0] res_out, max_abs;

  gsim_residual #(.N(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_en     (in_en),
    .b_in      (b_in),
    .x_valid   (x_valid),
    .x_in      (x_in),
    .res_valid (res_valid),
    .res_out   (res_out),
    .done      (done),
    .max_abs   (max_abs),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x  [16];
    logic [15:0] b  [16];
    logic [31:0] r  [16];
    logic [31:0] mx;
  } job_t;

  job_t jobs [6];

  int nvec = 0;
  int nmis = 0;

  // Edge counter and output monitor (sampled on the falling edge).
  int          cyc = 0;
  logic [31:0] res_log [$];
  int          rcyc_log [$];
  int          done_cnt = 0;
  int          done_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (res_valid) begin
      res_log.push_back(res_out);
      rcyc_log.push_back(cyc);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic init_jobs();
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < 16; i++) begin
        jobs[j].x[i] = '0;
        jobs[j].b[i] = '0;
        jobs[j].r[i] = '0;
      end
      jobs[j].mx = '0;
    end
    // Job 0: x all +32767.0; row coefficient sums 12,-1,5,4..4,5,-1,12.
    for (int i = 0; i < 16; i++) begin
      jobs[0].x[i] = 32'h7FFF_0000;
      jobs[0].r[i] = 32'h7FFF_FFFF;
    end
    jobs[0].r[1]  = 32'h8001_0000;
    jobs[0].r[14] = 32'h8001_0000;
    jobs[0].mx    = 32'h7FFF_FFFF;
    // Job 1: x zero, b0 = 5.
    jobs[1].b[0] = 16'd5;
    jobs[1].r[0] = 32'hFFFB_0000;
    jobs[1].mx   = 32'h0005_0000;
    // Job 2: x0 = 1.0.
    jobs[2].x[0] = 32'h0001_0000;
    jobs[2].r[0] = 32'h0014_0000;
    jobs[2].r[1] = 32'hFFF3_0000;
    jobs[2].r[2] = 32'h0006_0000;
    jobs[2].r[3] = 32'hFFFF_0000;
    jobs[2].mx   = 32'h0014_0000;
    // Job 3: x all -32768.0; negative saturation and |min| clamp.
    for (int i = 0; i < 16; i++) begin
      jobs[3].x[i] = 32'h8000_0000;
      jobs[3].r[i] = 32'h8000_0000;
    end
    jobs[3].r[1]  = 32'h7FFF_FFFF;
    jobs[3].r[14] = 32'h7FFF_FFFF;
    jobs[3].mx    = 32'h7FFF_FFFF;
    // Job 4: x zero, b extremes.
    jobs[4].b[0] = 16'h8000;
    jobs[4].b[1] = 16'h7FFF;
    jobs[4].b[2] = 16'd3;
    jobs[4].r[0] = 32'h7FFF_FFFF;
    jobs[4].r[1] = 32'h8001_0000;
    jobs[4].r[2] = 32'hFFFD_0000;
    jobs[4].mx   = 32'h7FFF_FFFF;
    // Job 5: interior x7 = 1.0 and trailing x15 = 0.5.
    jobs[5].x[7]  = 32'h0001_0000;
    jobs[5].x[15] = 32'h0000_8000;
    jobs[5].r[4]  = 32'hFFFF_0000;
    jobs[5].r[5]  = 32'h0006_0000;
    jobs[5].r[6]  = 32'hFFF3_0000;
    jobs[5].r[7]  = 32'h0014_0000;
    jobs[5].r[8]  = 32'hFFF3_0000;
    jobs[5].r[9]  = 32'h0006_0000;
    jobs[5].r[10] = 32'hFFFF_0000;
    jobs[5].r[12] = 32'hFFFF_8000;
    jobs[5].r[13] = 32'h0003_0000;
    jobs[5].r[14] = 32'hFFF9_8000;
    jobs[5].r[15] = 32'h000A_0000;
    jobs[5].mx    = 32'h0014_0000;
  endtask

  // Drive one job; the x stream leads the b stream by 'lead' cycles, then 'extra' junk x strobes.
  task automatic run_job(input int j, input int lead, input int extra, output int L);
    int last_t, total;
    last_t = 15 + lead;
    total  = (16 + extra > 16 + lead) ? 16 + extra : 16 + lead;
    L      = 0;
    for (int t = 0; t < total; t++) begin
      @(posedge clk); #1;
      in_en   = (t >= lead) && (t - lead < 16);
      b_in    = in_en ? jobs[j].b[t - lead] : 16'h0;
      x_valid = (t < 16 + extra);
      x_in    = (t < 16) ? jobs[j].x[t] : (x_valid ? 32'hDEAD_0000 : 32'h0);
      if (t == last_t) L = cyc + 1;
    end
    @(posedge clk); #1;
    in_en = 1'b0; x_valid = 1'b0; b_in = '0; x_in = '0;
  endtask

  task automatic finish_job(input int j, input int L, input int rbase, input int dbase);
    bit          seen;
    int          idx;
    logic [31:0] got;
    seen = 1'b0;
    for (int k = 0; k < 80 && !seen; k++) begin
      @(posedge clk); #1;
      if (done_cnt > dbase) seen = 1'b1;
    end
    chk($sformatf("job%0d done_seen", j), 32'(seen), 32'd1);
    chk($sformatf("job%0d done_count", j), 32'(done_cnt - dbase), 32'd1);
    chk($sformatf("job%0d done_cycle", j), 32'(done_cyc), 32'(L + 18));
    chk($sformatf("job%0d res_count", j), 32'(res_log.size() - rbase), 32'd16);
    got = (rbase < rcyc_log.size()) ? 32'(rcyc_log[rbase]) : 32'hFFFF_FFFF;
    chk($sformatf("job%0d first_res_cycle", j), got, 32'(L + 2));
    for (int i = 0; i < 16; i++) begin
      idx = rbase + i;
      got = (idx < res_log.size()) ? res_log[idx] : 32'hxxxx_xxxx;
      chk($sformatf("job%0d row%0d", j, i), got, jobs[j].r[i]);
    end
    chk($sformatf("job%0d max_abs", j), max_abs, jobs[j].mx);
    chk($sformatf("job%0d busy_low", j), 32'(busy), 32'd0);
  endtask

  initial begin
    int L, rbase, dbase;
    init_jobs();
    reset = 1'b1; in_en = 1'b0; x_valid = 1'b0; b_in = '0; x_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset res_valid", 32'(res_valid), 32'd0);
    chk("reset res_out", res_out, 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset max_abs", max_abs, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // Table jobs back to back: each starts the cycle after busy falls.
    for (int j = 0; j < 6; j++) begin
      rbase = res_log.size();
      dbase = done_cnt;
      run_job(j, 0, 0, L);
      if (j == 0) chk("busy_high_loading", 32'(busy), 32'd1);
      finish_job(j, L, rbase, dbase);
    end

    // x stream finishes 5 cycles before b, with 3 ignored extra x strobes.
    rbase = res_log.size();
    dbase = done_cnt;
    run_job(5, 5, 3, L);
    finish_job(5, L, rbase, dbase);

    // Reset during the 4th CALC cycle aborts the job silently.
    rbase = res_log.size();
    dbase = done_cnt;
    run_job(2, 0, 0, L);
    for (int k = 0; k < 20 && cyc < L + 4; k++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort res_valid", 32'(res_valid), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    repeat (25) @(posedge clk);
    #1;
    chk("abort no_done", 32'(done_cnt - dbase), 32'd0);
    chk("abort res_count", 32'(res_log.size() - rbase), 32'd3);

    // Fresh job after the abort.
    rbase = res_log.size();
    dbase = done_cnt;
    run_job(5, 0, 0, L);
    finish_job(5, L, rbase, dbase);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
